dac_segment_decoder: RTL
========================

Name: dac_segment_decoder

Overview:
Digital front end for the segmented current-steering DAC cell array. Converts an 11-bit code into 17 thermometer unit enables (weight 64 LSB each) plus 6 binary enables and one redundancy enable. Sequences the array's power-down (pdb) and analog testbus selection (atb_ena) through a power-up/power-down state machine. Sits between the digital datapath and the current source unit array; its outputs drive the array's switch and control inputs directly.

Parameters:
SETTLE_CYC, 64, bias settle time in clk cycles after pdb rises before codes are applied (min 1)
CODE_MAX, 1151, full-scale code = 17*64 + 63; larger inputs saturate

Ports:
clk  in  1  block clock
rst  in  1  asynchronous reset, active-high
en  in  1  power request; 1 = power up and run, 0 = ramp down and power off
din  in  11  unsigned DAC code
din_valid  in  1  din qualifier
din_ready  out  1  block accepts din this cycle
red_en_cfg  in  1  static: enable redundancy LSB unit
atb_sel  in  2  requested testbus selection
pdb  out  1  array power-down negate
atb_ena  out  2  array testbus selection
therm_en  out  17  thermometer unit enables
bin_en  out  6  binary unit enables, bit 5 = MSB
bin0_red_en  out  1  redundancy unit enable
sat  out  1  one-cycle pulse: accepted code exceeded CODE_MAX
active  out  1  FSM is in ACTIVE

Behaviour:
- Reset (async, immediate): FSM=OFF; pdb=0, atb_ena=0, therm_en=0, bin_en=0, bin0_red_en=0, sat=0, active=0, din_ready=0; settle counter=0; pipeline registers=0.
- FSM states: OFF, SETTLE, ACTIVE, RAMPDN.
  - OFF: pdb=0, all enables 0, atb_ena=0. en=1 -> SETTLE.
  - SETTLE: pdb=1, atb_ena=atb_sel (registered), enables 0, counter counts 0..SETTLE_CYC-1; on count==SETTLE_CYC-1 -> ACTIVE. en=0 here -> OFF directly, counter cleared.
  - ACTIVE: active=1, din_ready=1 when en=1. en=0 -> RAMPDN (din_ready=0 in the same cycle).
  - RAMPDN: din_ready=0; enables forced to 0 on the first RAMPDN cycle; pipeline flushed; pdb stays 1 for exactly 2 cycles, then -> OFF. en=1 during RAMPDN is ignored; reacquisition goes via OFF -> SETTLE.
- Handshake: word transferred when din_valid && din_ready. No backpressure inside ACTIVE.
- Pipeline: 2 cycles. Stage 1 (cycle N+1): saturate (c = din > CODE_MAX ? CODE_MAX : din), sat pulse, split n = c[10:6] (0..17), b = c[5:0]. Stage 2 (cycle N+2): therm_en has exactly n ones, bin_en = b, bin0_red_en = red_en_cfg & b[0].
- No valid word: outputs hold the last decoded code. Back-to-back words each give an updated output on consecutive cycles.
- Boundary: din=0 -> all enables 0. din=1151 -> therm_en=all 17 ones, bin_en=6'h3F. din=2047 -> same as 1151, sat=1 for one cycle.
- atb_ena follows atb_sel with 1-cycle delay in SETTLE/ACTIVE/RAMPDN and is 0 in OFF.

Optional Feature:
DAC_DEM_EN: with the macro defined, thermometer dynamic element matching is used. A 5-bit pointer p (0..16, reset 0) selects the enabled units p..p+n-1 modulo 17. After each stage-2 update, p <= (p+n) mod 17. p is cleared on entry to OFF. Without the macro, the enabled units are therm_en[n-1:0] and no pointer exists. In both builds the popcount of therm_en equals n.

Test Plan:
- Reset mid-ACTIVE with therm_en nonzero -> all outputs 0 asynchronously, FSM=OFF.
- en=1, SETTLE_CYC=64 -> pdb=1 the cycle after en; active=1 and din_ready=1 64 cycles later; enables 0 throughout SETTLE.
- ACTIVE, din=200 valid at N -> at N+2, therm_en=17'h00007 and bin_en=6'd8; with red_en_cfg=1, din=201 -> bin0_red_en=1.
- din=2047 -> sat pulse at N+1; therm_en=17'h1FFFF and bin_en=6'h3F at N+2; din=0 next cycle -> all 0 one cycle later.
- en dropped in ACTIVE -> din_ready=0 the same cycle, enables 0 the next cycle, pdb=0 after 2 RAMPDN cycles; en=0 during SETTLE -> OFF immediately.
- DAC_DEM_EN: codes 128, 128, 640 -> therm_en = units{0,1}, then units{2,3}, then units{4..13}; pointer then equals 14.

Source files
------------

// File: rtl/dac_segment_decoder.sv
// dac_segment_decoder: 11-bit code to 17 thermometer + 6 binary + redundancy enables with power sequencing FSM
// Optional build macro DAC_DEM_EN: rotates thermometer units with a dynamic element matching pointer.
module dac_segment_decoder #(
    parameter int SETTLE_CYC = 64,
    parameter int CODE_MAX   = 1151
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [10:0] din,
    input  logic        din_valid,
    output logic        din_ready,
    input  logic        red_en_cfg,
    input  logic [1:0]  atb_sel,
    output logic        pdb,
    output logic [1:0]  atb_ena,
    output logic [16:0] therm_en,
    output logic [5:0]  bin_en,
    output logic        bin0_red_en,
    output logic        sat,
    output logic        active
);
    typedef enum logic [1:0] {OFF, SETTLE, ACTIVE, RAMPDN} state_t;
    localparam int CW = (SETTLE_CYC > 2) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [10:0] CMAX = 11'(CODE_MAX);
    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic          acc, s1_valid, upd;
    logic [10:0]   c;
    logic [4:0]    s1_n;
    logic [5:0]    s1_b;
    logic [16:0]   mask, therm_nx;
    assign din_ready = (state == ACTIVE) && en;
    assign acc       = din_valid && din_ready;
    assign c         = (din > CMAX) ? CMAX : din;
    assign upd       = s1_valid && (state_nx == ACTIVE);
    // next state: SETTLE and RAMPDN leave on their cycle counts, en=0 aborts SETTLE
    always_comb begin
        state_nx = state;
        case (state)
            OFF:     state_nx = en ? SETTLE : OFF;
            SETTLE:  state_nx = !en ? OFF : (cnt == CW'(SETTLE_CYC - 1)) ? ACTIVE : SETTLE;
            ACTIVE:  state_nx = en ? ACTIVE : RAMPDN;
            default: state_nx = (cnt == CW'(1)) ? OFF : RAMPDN;
        endcase
    end
    // state, dwell counter and registered array control outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= OFF;
            cnt     <= '0;
            pdb     <= 1'b0;
            atb_ena <= 2'b0;
            active  <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= (state_nx == state && (state == SETTLE || state == RAMPDN)) ? cnt + 1'b1 : '0;
            pdb     <= state_nx != OFF;
            atb_ena <= (state_nx != OFF) ? atb_sel : 2'b0;
            active  <= state_nx == ACTIVE;
        end
    end
    // n lowest units set; DEM rotates this window
    always_comb begin
        mask = '0;
        for (int i = 0; i < 17; i++) mask[i] = 5'(i) < s1_n;
    end
`ifdef DAC_DEM_EN
    logic [4:0] ptr;
    logic [5:0] psum;
    assign therm_nx = (mask << ptr) | (mask >> (5'd17 - ptr));
    assign psum     = {1'b0, ptr} + {1'b0, s1_n};
    // pointer advances by the units just used, restarting at 0 whenever the array powers off
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr <= '0;
        else if (state_nx == OFF) ptr <= '0;
        else if (upd) ptr <= (psum >= 6'd17) ? 5'(psum - 6'd17) : psum[4:0];
    end
`else
    assign therm_nx = mask;
`endif
    // two-stage decode: saturate/split, then drive enables; anything outside ACTIVE clears them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_n        <= '0;
            s1_b        <= '0;
            sat         <= 1'b0;
            therm_en    <= '0;
            bin_en      <= '0;
            bin0_red_en <= 1'b0;
        end else begin
            s1_valid <= acc;
            sat      <= acc && (din > CMAX);
            if (acc) begin
                s1_n <= c[10:6];
                s1_b <= c[5:0];
            end
            if (state_nx != ACTIVE) begin
                therm_en    <= '0;
                bin_en      <= '0;
                bin0_red_en <= 1'b0;
            end else if (s1_valid) begin
                therm_en    <= therm_nx;
                bin_en      <= s1_b;
                bin0_red_en <= red_en_cfg & s1_b[0];
            end
        end
    end
endmodule
